// File: rtl/inport_controller_pkg.sv
// Shared types and default constants for the input-port controller.
package inport_pkg;

  // Button debounce FSM states
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned INPORT_SYNC_STAGES     = 2;
  localparam int unsigned INPORT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/inport_controller_if.sv
// Datapath-side bus of the input port: read strobe in, data and status out.
// Optional macro INPORT_IRQ_EN adds the inport_irq pulse.
interface inport_controller_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] inport_data;
  logic                  data_valid;
  logic                  overrun;
  logic                  Inport_out;
`ifdef INPORT_IRQ_EN
  logic                  inport_irq;
`endif

  // Datapath / CPU side
  modport master (
`ifdef INPORT_IRQ_EN
    input  inport_irq,
`endif
    input  inport_data, data_valid, overrun,
    output Inport_out
  );

  // Controller side
  modport slave (
`ifdef INPORT_IRQ_EN
    output inport_irq,
`endif
    output inport_data, data_valid, overrun,
    input  Inport_out
  );
endinterface

// File: rtl/inport_controller_button_debounce.sv
// Strobe button synchronizer + debounce FSM; emits one capture pulse per press.
// Sync flops reset to "pressed" so a button held through reset is ignored
// until it has been cleanly released.
module button_debounce
  import inport_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = INPORT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = INPORT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic strobe_btn,
  output logic capture_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   btn_s;
  btn_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign btn_s = btn_sync[SYNC_STAGES-1];

  // Button synchronizer chain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) btn_sync <= '1;
    else        btn_sync <= {btn_sync[SYNC_STAGES-2:0], strobe_btn};
  end

  // FSM state and stability counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RELEASE_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter update and capture pulse; counter clears on every state change
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HELD;
          cnt_d     = '0;
          capture_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/inport_controller.sv
// Input port: synchronized switches captured on each debounced button press,
// held for the datapath with valid/overrun status.
// Optional macro INPORT_IRQ_EN adds a one-cycle inport_irq pulse after each capture.
module inport_controller
  import inport_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IN_WIDTH        = 8,
  parameter int unsigned SYNC_STAGES     = INPORT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = INPORT_DEBOUNCE_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] switches,
  input  logic                strobe_btn,
  inport_controller_if.slave  bus
);

  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sw_sync;
  logic [IN_WIDTH-1:0]                  sw_s;
  logic [IN_WIDTH-1:0]                  hold_q;
  logic                                 valid_q;
  logic                                 overrun_q;
  logic                                 capture_c;

  assign sw_s = sw_sync[SYNC_STAGES-1];

  button_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock     (clock),
    .reset     (reset),
    .strobe_btn(strobe_btn),
    .capture_c (capture_c)
  );

  // Switch synchronizer chain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sw_sync <= '0;
    else        sw_sync <= {sw_sync[SYNC_STAGES-2:0], switches};
  end

  // Holding register and status flags; a capture takes priority over a read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (capture_c) begin
      hold_q    <= sw_s;
      valid_q   <= 1'b1;
      overrun_q <= bus.Inport_out ? 1'b0 : (overrun_q | valid_q);
    end else if (bus.Inport_out) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign bus.inport_data = DATA_WIDTH'(hold_q);
  assign bus.data_valid  = valid_q;
  assign bus.overrun     = overrun_q;

`ifdef INPORT_IRQ_EN
  logic irq_q;

  // One-cycle interrupt pulse following each capture edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= capture_c;
  end

  assign bus.inport_irq = irq_q;
`endif

endmodule

// File: tb/tb_inport_controller.sv
// Directed bench for inport_controller (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_inport_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] switches;
  logic       strobe_btn;
  int         checks = 0;
  int         errors = 0;

  inport_controller_if #(.DATA_WIDTH(32)) bus ();

  inport_controller #(
    .DATA_WIDTH     (32),
    .IN_WIDTH       (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .switches  (switches),
    .strobe_btn(strobe_btn),
    .bus       (bus.slave)
  );

  always #5 clock = ~clock;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic read_pulse();
    bus.Inport_out = 1'b1;
    tick(1);
    bus.Inport_out = 1'b0;
  endtask

  // Clean press of hi cycles, then release long enough to return to IDLE
  task automatic press_release(input int hi);
    strobe_btn = 1'b1;
    tick(hi);
    strobe_btn = 1'b0;
    tick(12);
  endtask

  initial begin
    reset          = 1'b0;
    switches       = 8'h00;
    strobe_btn     = 1'b1;
    bus.Inport_out = 1'b0;

    // 1: button held through reset never captures
    tick(3);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_data", bus.inport_data, 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("held_valid", 32'(bus.data_valid), 32'd0);
    end
    check("held_data", bus.inport_data, 32'd0);
    check("held_overrun", 32'(bus.overrun), 32'd0);
    strobe_btn = 1'b0;
    tick(12);
    check("released_valid", 32'(bus.data_valid), 32'd0);

    // 2: capture latency and read
    switches   = 8'hA5;
    strobe_btn = 1'b1;
    tick(6);
    check("lat_edge6_valid", 32'(bus.data_valid), 32'd0);
    tick(1);
    check("lat_edge7_valid", 32'(bus.data_valid), 32'd1);
    check("lat_data", bus.inport_data, 32'h0000_00A5);
    check("lat_overrun", 32'(bus.overrun), 32'd0);
`ifdef INPORT_IRQ_EN
    check("irq_high", 32'(bus.inport_irq), 32'd1);
`endif
    read_pulse();
    check("read_valid", 32'(bus.data_valid), 32'd0);
    check("read_data", bus.inport_data, 32'h0000_00A5);
`ifdef INPORT_IRQ_EN
    check("irq_low", 32'(bus.inport_irq), 32'd0);
`endif
    tick(10);
    check("no_repeat_valid", 32'(bus.data_valid), 32'd0);
    strobe_btn = 1'b0;
    tick(12);

    // 3: bounce rejected, then one clean capture
    switches   = 8'h5C;
    strobe_btn = 1'b1; tick(3);
    strobe_btn = 1'b0; tick(1);
    strobe_btn = 1'b1; tick(3);
    strobe_btn = 1'b0; tick(12);
    check("bounce_valid", 32'(bus.data_valid), 32'd0);
    check("bounce_data", bus.inport_data, 32'h0000_00A5);
    press_release(5);
    check("clean_valid", 32'(bus.data_valid), 32'd1);
    check("clean_data", bus.inport_data, 32'h0000_005C);
    check("clean_overrun", 32'(bus.overrun), 32'd0);
    read_pulse();
    check("clean_read_valid", 32'(bus.data_valid), 32'd0);

    // 4: overrun on unread capture, cleared by a read
    switches = 8'h12;
    press_release(6);
    check("ovr1_data", bus.inport_data, 32'h0000_0012);
    check("ovr1_overrun", 32'(bus.overrun), 32'd0);
    switches = 8'h34;
    press_release(6);
    check("ovr2_data", bus.inport_data, 32'h0000_0034);
    check("ovr2_valid", 32'(bus.data_valid), 32'd1);
    check("ovr2_overrun", 32'(bus.overrun), 32'd1);
    read_pulse();
    check("ovr_read_valid", 32'(bus.data_valid), 32'd0);
    check("ovr_read_overrun", 32'(bus.overrun), 32'd0);
    check("ovr_read_data", bus.inport_data, 32'h0000_0034);
    read_pulse();
    check("idle_read_valid", 32'(bus.data_valid), 32'd0);
    check("idle_read_overrun", 32'(bus.overrun), 32'd0);

    // 5: read in the capture cycle while valid -> capture wins, no overrun
    switches = 8'h11;
    press_release(6);
    check("sim_pre_data", bus.inport_data, 32'h0000_0011);
    check("sim_pre_valid", 32'(bus.data_valid), 32'd1);
    switches   = 8'h7E;
    strobe_btn = 1'b1;
    tick(6);
    bus.Inport_out = 1'b1;
    tick(1);
    bus.Inport_out = 1'b0;
    check("sim_data", bus.inport_data, 32'h0000_007E);
    check("sim_valid", 32'(bus.data_valid), 32'd1);
    check("sim_overrun", 32'(bus.overrun), 32'd0);
    strobe_btn = 1'b0;
    tick(12);

    // 6: reset mid PRESS_WAIT clears immediately; capture needs a full release
    switches   = 8'h99;
    strobe_btn = 1'b1;
    tick(5);
    #1 reset = 1'b0;
    #1;
    check("arst_valid", 32'(bus.data_valid), 32'd0);
    check("arst_data", bus.inport_data, 32'd0);
    check("arst_overrun", 32'(bus.overrun), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(10);
    check("arst_held_valid", 32'(bus.data_valid), 32'd0);
    strobe_btn = 1'b0; tick(2);
    strobe_btn = 1'b1; tick(10);
    check("short_release_valid", 32'(bus.data_valid), 32'd0);
    check("short_release_data", bus.inport_data, 32'd0);
    strobe_btn = 1'b0;
    tick(12);
    press_release(6);
    check("after_rst_valid", 32'(bus.data_valid), 32'd1);
    check("after_rst_data", bus.inport_data, 32'h0000_0099);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
